// File: rtl/alu_div_seq.sv
// rtl/alu_div_seq.sv - RV32M sequential restoring divider driving a shared external adder-subtractor.
// All negation and trial subtraction go through add_a/add_b/add_mode -> add_s/add_co.
module alu_div_seq #(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] add_a,
  output logic [XLEN-1:0] add_b,
  output logic            add_mode,
  input  logic [XLEN-1:0] add_s,
  input  logic            add_co
);

  localparam int CW = $clog2(ITERS);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_NEG_N, S_NEG_D, S_DIV, S_FIX, S_DONE
  } state_t;

  state_t state, state_nx;

  logic            is_rem, neg_n, neg_d;
  logic [XLEN-1:0] dvd, dvs, rn, q, r, d;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] sh;
  logic            ok, negate;

  always_comb begin
    state_nx = state;
    add_a    = '0;
    add_b    = '0;
    add_mode = 1'b0;
    negate   = 1'b0;
    sh       = {r[XLEN-2:0], q[XLEN-1]};
    // A set R MSB means the shifted remainder is 33 bits wide and certainly >= D.
    ok       = add_co | r[XLEN-1];
    case (state)
      S_IDLE:  if (start) state_nx = S_NEG_N;
      S_NEG_N: begin
        add_b    = dvd;
        add_mode = 1'b1;
        state_nx = S_NEG_D;
      end
      S_NEG_D: begin
        add_b    = dvs;
        add_mode = 1'b1;
        state_nx = S_DIV;
      end
      S_DIV: begin
        add_a    = sh;
        add_b    = d;
        add_mode = 1'b1;
        if (cnt == LAST) state_nx = S_FIX;
      end
      S_FIX: begin
        add_mode = 1'b1;
        if (is_rem) begin
          add_b  = r;
          negate = neg_n;
        end else begin
          add_b  = q;
          negate = (neg_n ^ neg_d) && (dvs != '0);
        end
        state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy = (state == S_NEG_N) || (state == S_NEG_D) || (state == S_DIV) || (state == S_FIX);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      is_rem <= 1'b0;
      neg_n  <= 1'b0;
      neg_d  <= 1'b0;
      dvd    <= '0;
      dvs    <= '0;
      rn     <= '0;
      q      <= '0;
      r      <= '0;
      d      <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (start) begin
          is_rem <= op[1];
          neg_n  <= ~op[0] & dividend[XLEN-1];
          neg_d  <= ~op[0] & divisor[XLEN-1];
          dvd    <= dividend;
          dvs    <= divisor;
        end
        S_NEG_N: rn <= neg_n ? add_s : dvd;
        S_NEG_D: begin
          d   <= neg_d ? add_s : dvs;
          q   <= rn;
          r   <= '0;
          cnt <= '0;
        end
        S_DIV: begin
          r   <= ok ? add_s : sh;
          q   <= {q[XLEN-2:0], ok};
          cnt <= cnt + 1'b1;
        end
        S_FIX:   result <= negate ? add_s : add_b;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_seq.sv
// tb/tb_alu_div_seq.sv - self-checking bench for alu_div_seq with a behavioural adder and RV32M reference.
module tb_alu_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend, divisor;
  logic        busy, done;
  logic [31:0] result, add_a, add_b, add_s;
  logic        add_mode, add_co;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Behavioural 32-bit adder-subtractor; subtract carry-out is 1 when A >= B.
  always_comb begin
    if (add_mode) {add_co, add_s} = {1'b0, add_a} + {1'b0, ~add_b} + 33'd1;
    else          {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b};
  end

  alu_div_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .result(result),
    .add_a(add_a), .add_b(add_b), .add_mode(add_mode),
    .add_s(add_s), .add_co(add_co)
  );

  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: ref_div = (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      2'd1: ref_div = (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'd2: ref_div = (b == 0) ? a : 32'(sa % sb);
      default: ref_div = (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit poke);
    int cyc;
    logic [31:0] exp;
    exp = ref_div(o, a, b);
    @(negedge clk);
    op = o; dividend = a; divisor = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    cyc = 0;
    while (!done && cyc < 100) begin
      if (poke) begin
        start    = 1'($urandom_range(0, 1));
        op       = 2'($urandom);
        dividend = $urandom;
        divisor  = $urandom;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("latency", cyc, 35);
    check("busy_at_done", {31'd0, busy}, 32'd0);
    check($sformatf("result op=%0d a=%h b=%h", o, a, b), result, exp);
    @(negedge clk);
    check("single_done_pulse", {31'd0, done}, 32'd0);
    check("idle_not_busy", {31'd0, busy}, 32'd0);
    check("result_held", result, exp);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'd0; dividend = '0; divisor = '0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_add_a", add_a, 32'd0);
    check("rst_add_b", add_b, 32'd0);
    check("rst_add_mode", {31'd0, add_mode}, 32'd0);
    @(negedge clk) rst = 1'b0;

    run_op(2'd1, 32'd100, 32'd7, 1'b0);
    run_op(2'd3, 32'd100, 32'd7, 1'b0);
    run_op(2'd0, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(2'd2, 32'd7, 32'hFFFF_FFFE, 1'b0);
    run_op(2'd1, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(2'd0, 32'd5, 32'd0, 1'b0);
    run_op(2'd2, 32'hFFFF_FFFB, 32'd0, 1'b0);
    run_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'd3, 32'h8000_0000, 32'd0, 1'b0);
    run_op(2'd1, 32'h1234_5678, 32'h8000_0000, 1'b0);

    // Start pulses with fresh operands while busy must be ignored.
    run_op(2'd0, 32'hDEAD_BEEF, 32'd12345, 1'b1);
    run_op(2'd3, 32'hCAFE_F00D, 32'h0000_0FFF, 1'b1);

    // Reset in the middle of the DIV iterations.
    @(negedge clk);
    op = 2'd1; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_add_a", add_a, 32'd0);
    check("midrst_add_b", add_b, 32'd0);
    check("midrst_add_mode", {31'd0, add_mode}, 32'd0);
    @(negedge clk) rst = 1'b0;
    begin
      int seen;
      seen = 0;
      repeat (40) begin
        @(negedge clk);
        if (done) seen++;
      end
      check("midrst_no_done", seen, 0);
    end
    run_op(2'd1, 32'd1000, 32'd3, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (i % 4 == 0) ? ($urandom >> $urandom_range(0, 31)) : $urandom;
      if (i == 7) b = 32'd0;
      run_op(2'($urandom), a, b, (i % 5 == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
